// File: rtl/wb_regfile.sv
// wb_regfile: 32-entry register file with same-cycle write-back bypass and
// per-register pending-write counters that produce issue stalls and busy bits.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [5:0]        wb_reg_i,
  input  logic [4:0]        rd1_addr_i,
  input  logic [4:0]        rd2_addr_i,
  output logic [DATA_W-1:0] rd1_data_o,
  output logic [DATA_W-1:0] rd2_data_o,
  input  logic              iss_valid_i,
  input  logic [5:0]        iss_dst_i,
  output logic              stall_o,
  output logic [31:0]       busy_o,
  output logic              err_o
);

  localparam int NREG = 32;
  localparam logic [CNT_W-1:0] CMAX = '1;

  // Architectural state
  logic [DATA_W-1:0] r_mem [NREG];
  logic [CNT_W-1:0]  r_cnt [NREG];
  logic              r_err;

  // Per-register decode and counter bookkeeping
  logic [NREG-1:0]   w_hit;      // write-back targets register n this cycle
  logic [NREG-1:0]   w_nz;       // counter currently non-zero
  logic [NREG-1:0]   w_dec;      // write-back retires one pending write
  logic [NREG-1:0]   w_inc;      // accepted issue adds one pending write
  logic [NREG-1:0]   w_full;     // effective count sits at CMAX
  logic [CNT_W-1:0]  w_eff     [NREG];
  logic [CNT_W-1:0]  w_cnt_nxt [NREG];
  logic              w_wb_en;
  logic [4:0]        w_wb_idx;
  logic              w_accept;

  assign w_wb_en  = wb_reg_i[5];
  assign w_wb_idx = wb_reg_i[4:0];

  genvar n;
  generate
    for (n = 0; n < NREG; n++) begin : g_reg
      assign w_hit[n]  = w_wb_en && (w_wb_idx == 5'(n));
      assign w_nz[n]   = |r_cnt[n];
      assign w_dec[n]  = w_hit[n] && w_nz[n];
      // Effective count already credits a write-back landing this cycle,
      // so a dependent instruction can issue in the same cycle.
      assign w_eff[n]  = r_cnt[n] - CNT_W'(w_dec[n]);
      assign busy_o[n] = |w_eff[n];
      assign w_full[n] = (w_eff[n] == CMAX);
      assign w_inc[n]  = w_accept && (iss_dst_i[4:0] == 5'(n));
      // Issue is blocked at CMAX, so +inc never overflows; -dec only when non-zero.
      assign w_cnt_nxt[n] = r_cnt[n] + CNT_W'(w_inc[n]) - CNT_W'(w_dec[n]);
    end
  endgenerate

  // Issue hazard: any source still pending, or destination counter saturated
  assign stall_o  = iss_valid_i &&
                    (busy_o[rd1_addr_i] || busy_o[rd2_addr_i] ||
                     (iss_dst_i[5] && w_full[iss_dst_i[4:0]]));
  assign w_accept = iss_valid_i && !stall_o && iss_dst_i[5];

  // Combinational read ports with write-back bypass
  assign rd1_data_o = (w_wb_en && (w_wb_idx == rd1_addr_i)) ? wb_data_i : r_mem[rd1_addr_i];
  assign rd2_data_o = (w_wb_en && (w_wb_idx == rd2_addr_i)) ? wb_data_i : r_mem[rd2_addr_i];

  assign err_o = r_err;

  // Register storage: write-back data lands on the edge; reset clears all entries
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (w_wb_en) begin
      r_mem[w_wb_idx] <= wb_data_i;
    end
  end

  // Pending-write counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Sticky error: write-back to a register with nothing outstanding
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          r_err <= 1'b0;
    else if (w_wb_en && !w_nz[w_wb_idx]) r_err <= 1'b1;
  end

endmodule
